gol_board_engine: RTL and testbench
===================================

Name: gol_board_engine

Overview:
- Consumer end of the Game of Life control interface. Takes `game_state[1:0]` and `cell_idx[6:0]` from the control FSM, plus the player buttons.
- Owns the cell board: programs cells in PROGRAM, clears the board in IDLE, and in RUN computes successive generations (rule B3/S23, toroidal wrap) one cell per clock.
- Drives the board vector and status to the display/LED logic.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns; N = ROWS*COLS, N <= 128.
- GEN_PERIOD, 1000, RUN clocks counted between generation starts (>= 1).

Ports:
- clka  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- game_state  in  2  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- cell_idx  in  7  target cell in PROGRAM; index = row*COLS + col.
- btn0  in  1  single-cycle pulse; clears cell at cell_idx.
- btn1  in  1  single-cycle pulse; sets cell at cell_idx.
- board  out  N  current generation; bit i = cell i alive.
- generation  out  16  generation counter.
- alive_count  out  7  live cells in board.
- busy  out  1  high while a sweep is in progress.
- gen_done  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset (async) sets board, shadow, generation, alive_count, period counter and sweep index to 0. It also sets busy=0, gen_done=0 and the engine state to HOLD.
- Engine states:
  - HOLD: no sweep.
  - COUNT: period counting.
  - SWEEP: computing cells.
  - COMMIT: one cycle.
- game_state IDLE (any engine state, including mid-sweep):
  - Next clock: board, shadow, generation, alive_count and period counter go to 0; engine state goes to HOLD.
  - An active sweep is aborted; gen_done is not pulsed.
- game_state PROGRAM, engine in HOLD:
  - btn1=1, btn0=0: board[cell_idx] <= 1.
  - btn0=1, btn1=0: board[cell_idx] <= 0.
  - Both buttons or neither: no change.
  - cell_idx >= N: ignored.
  - alive_count tracks board with 1-cycle lag. generation is unchanged.
- game_state RUN:
  - HOLD moves to COUNT with the period counter at 0.
  - COUNT increments the counter each clock. When counter == GEN_PERIOD-1, the next state is SWEEP with idx=0 and busy=1.
  - SWEEP, each clock: shadow[idx] <= rule(board[idx], neighbour count of board at idx).
  - Neighbours are the 8 surrounding cells; row and column wrap modulo ROWS/COLS.
  - Rule: alive next iff count==3, or (alive now and count==2).
  - After idx==N-1 the next state is COMMIT.
  - COMMIT, for one cycle:
    - board <= shadow.
    - generation <= generation+1 (wraps FFFF to 0000).
    - alive_count <= popcount(shadow).
    - gen_done=1 and busy=0.
    - Next state is COUNT with the counter at 0.
  - board is not modified during SWEEP.
  - Latency from the first RUN cycle in HOLD: COUNT is entered after 1 cycle; gen_done is high in cycle 1 + GEN_PERIOD + N (0-based, RUN entry = cycle 0).
  - Steady-state spacing between gen_done pulses: GEN_PERIOD + N + 1 cycles.
- game_state PAUSE:
  - COUNT freezes its counter.
  - SWEEP/COMMIT run to completion (committing the generation), then the engine goes to HOLD with the counter at 0.
  - Buttons are ignored.
  - Returning to RUN from a frozen COUNT resumes counting from the held value.
- In PROGRAM, buttons are acted on only in HOLD. If PROGRAM arrives mid-sweep, the sweep completes and commits first; button pulses during it are dropped.
- gen_done is never high for more than 1 cycle. busy is high exactly during the N SWEEP cycles.

Test Plan:
- Reset: assert rst mid-clock with board nonzero -> board, generation, alive_count, busy and gen_done are 0 immediately, without waiting for a clock edge.
- Program, then blinker (GEN_PERIOD=4): in PROGRAM, btn1 at idx 26, 27, 28, then idx 200->ignored (7-bit 72, >=64). Then RUN.
  - Expect alive_count=3 after programming.
  - gen_done at cycle 69 after RUN entry.
  - board = bits 19, 27, 35; generation=1.
  - Second gen_done 69 cycles later restores 26, 27, 28; generation=2.
- Buttons: btn0 and btn1 together at idx 5 -> bit 5 unchanged. btn0 at a set cell -> cleared. Pulses sent during RUN -> ignored.
- Wrap: glider at cells 1, 10, 16, 17, 18 (GEN_PERIOD=1).
  - After 4 generations the pattern is shifted +1 row and +1 col: 10, 19, 25, 26, 27.
  - After 32 generations (8 rows × 4 generations per row) the glider has crossed the torus boundary and returned to 1, 10, 16, 17, 18.
  - alive_count stays 5 throughout.
- PAUSE mid-sweep:
  - Switch to PAUSE while busy with idx~30 -> sweep finishes, gen_done pulses once, generation increments, then no further change for 500 cycles.
  - PAUSE during COUNT at counter=2, then RUN -> gen_done after exactly 2 + N + 1 more cycles.
- IDLE mid-sweep: switch to IDLE during SWEEP -> next clock board=0, generation=0, busy=0, with no gen_done pulse.

Source files
------------

// File: rtl/gol_board_engine_if.sv
// Control/display interface of the Game of Life board engine: game state,
// target cell and player buttons in; board vector and generation status out.
interface gol_board_engine_if #(
  parameter int N = 64
);
  logic [1:0]   game_state;
  logic [6:0]   cell_idx;
  logic         btn0;
  logic         btn1;
  logic [N-1:0] board;
  logic [15:0]  generation;
  logic [6:0]   alive_count;
  logic         busy;
  logic         gen_done;

  modport master (
    output game_state, cell_idx, btn0, btn1,
    input  board, generation, alive_count, busy, gen_done
  );

  modport slave (
    input  game_state, cell_idx, btn0, btn1,
    output board, generation, alive_count, busy, gen_done
  );
endinterface

// File: rtl/gol_board_engine.sv
// Game of Life board engine: holds the cell board, lets the player program it,
// and in RUN computes B3/S23 generations on a torus, one cell per clock.
module gol_board_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int GEN_PERIOD = 1000
) (
  input  logic               clka,
  input  logic               rst,
  gol_board_engine_if.slave  bus
);
  localparam int N    = ROWS * COLS;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(GEN_PERIOD + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(GEN_PERIOD - 1);

  typedef enum logic [1:0] {GS_IDLE, GS_PROGRAM, GS_RUN, GS_PAUSE} game_state_t;
  typedef enum logic [1:0] {HOLD, COUNT, SWEEP, COMMIT} engine_state_t;

  game_state_t   gs;
  engine_state_t state_q, state_d;

  logic [N-1:0]      board_q;
  logic [N-1:0]      shadow_q;
  logic [15:0]       gen_q;
  logic [6:0]        alive_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   idx_q;

  logic [3:0]        nbr_count;
  logic              next_cell;
  int                cur_row, cur_col, nr, nc;

  assign gs = game_state_t'(bus.game_state);

  function automatic logic [6:0] popcount(input logic [N-1:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + 7'(v[i]);
    return s;
  endfunction

  // Neighbour count of the cell under the sweep index, rows/cols wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nbr_count = '0;
    nr        = 0;
    nc        = 0;
    cur_row   = int'(idx_q) / COLS;
    cur_col   = int'(idx_q) % COLS;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          nr        = (cur_row + dr + ROWS) % ROWS;
          nc        = (cur_col + dc + COLS) % COLS;
          nbr_count = nbr_count + 4'(board_q[IDXW'(nr * COLS + nc)]);
        end
      end
    end
    next_cell = (nbr_count == 4'd3) || (board_q[idx_q] && nbr_count == 4'd2);
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) state_q <= HOLD;
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    else     state_q <= state_d;
  end

  // Only IDLE can abort a sweep; PAUSE and PROGRAM let it commit first.
  always_comb begin
    state_d = state_q;
    if (gs == GS_IDLE) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD:   if (gs == GS_RUN) state_d = COUNT;
        COUNT: begin
          if (gs == GS_RUN && cnt_q == LAST_CNT) state_d = SWEEP;
          else if (gs == GS_PROGRAM)             state_d = HOLD;
        end
        SWEEP:  if (idx_q == LAST_IDX) state_d = COMMIT;
        COMMIT: state_d = (gs == GS_RUN) ? COUNT : HOLD;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      board_q  <= '0;
      shadow_q <= '0;
      gen_q    <= '0;
      alive_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else if (gs == GS_IDLE) begin
      board_q  <= '0;
      shadow_q <= '0;
      gen_q    <= '0;
      alive_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      alive_q <= popcount(board_q);
      case (state_q)
        HOLD: begin
          cnt_q <= '0;
          if (gs == GS_PROGRAM && (bus.btn0 ^ bus.btn1) && int'(bus.cell_idx) < N)
            board_q[bus.cell_idx[IDXW-1:0]] <= bus.btn1;
        end
        COUNT: begin
          if (gs == GS_RUN) begin
            if (cnt_q == LAST_CNT) begin
              cnt_q <= '0;
              idx_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (gs == GS_PROGRAM) begin
            cnt_q <= '0;
          end
        end
        SWEEP: begin
          shadow_q[idx_q] <= next_cell;
          idx_q           <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        COMMIT: begin
          board_q <= shadow_q;
          gen_q   <= gen_q + 16'd1;
          alive_q <= popcount(shadow_q);
          cnt_q   <= '0;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign bus.board       = board_q;
  assign bus.generation  = gen_q;
  assign bus.alive_count = alive_q;
  assign bus.busy        = (state_q == SWEEP);
  assign bus.gen_done    = (state_q == COMMIT) && (gs != GS_IDLE);
endmodule

// File: tb/tb_gol_board_engine.sv
// Directed bench for gol_board_engine: reset, programming, blinker, pause,
// idle abort (GEN_PERIOD=4 instance) and toroidal glider (GEN_PERIOD=1 instance).
module tb_gol_board_engine;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int P    = 4;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] PROGRAM = 2'b01;
  localparam logic [1:0] RUN     = 2'b10;
  localparam logic [1:0] PAUSE   = 2'b11;

  localparam logic [N-1:0] BLINK_H  = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [N-1:0] BLINK_V  = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [N-1:0] GLIDER_0 = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                      (64'd1 << 17) | (64'd1 << 18);
  localparam logic [N-1:0] GLIDER_4 = (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 25) |
                                      (64'd1 << 26) | (64'd1 << 27);

  logic clka = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clka = ~clka;

  gol_board_engine_if #(.N(N)) bus ();
  gol_board_engine_if #(.N(N)) gbus ();

  gol_board_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_PERIOD(P)) dut (
    .clka (clka), .rst (rst), .bus (bus)
  );
  gol_board_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_PERIOD(1)) dut_g (
    .clka (clka), .rst (rst), .bus (gbus)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clka);
  endtask

  // One-cycle button pulse on the main instance, starting at a negedge.
  task automatic press(input logic [6:0] idx, input logic b0, input logic b1);
    bus.cell_idx = idx;
    bus.btn0     = b0;
    bus.btn1     = b1;
    step(1);
    bus.btn0 = 1'b0;
    bus.btn1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.game_state  = IDLE;  bus.cell_idx  = '0; bus.btn0  = 0; bus.btn1  = 0;
    gbus.game_state = IDLE;  gbus.cell_idx = '0; gbus.btn0 = 0; gbus.btn1 = 0;
    step(2);
    rst = 1'b0;
    step(1);
    checks++;
    if (bus.board !== '0 || bus.generation !== 16'd0 || bus.busy !== 1'b0 || bus.gen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: board=%h gen=%0d busy=%b done=%b, expected all zero",
               bus.board, bus.generation, bus.busy, bus.gen_done);
    end
    bus.game_state = PROGRAM;
    press(7'd3, 1'b0, 1'b1);
    step(1);
    checks++;
    if (bus.board !== (64'd1 << 3) || bus.alive_count !== 7'd1) begin
      errors++;
      $display("FAIL reset_preload: board=%h alive=%0d, expected %h alive=1",
               bus.board, bus.alive_count, 64'd1 << 3);
    end
    // Assert reset between edges; outputs must clear before any posedge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.board !== '0 || bus.generation !== 16'd0 || bus.alive_count !== 7'd0 ||
        bus.busy !== 1'b0 || bus.gen_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: board=%h gen=%0d alive=%0d busy=%b done=%b, expected all zero",
               bus.board, bus.generation, bus.alive_count, bus.busy, bus.gen_done);
    end
    @(negedge clka);
    rst = 1'b0;
    bus.game_state = IDLE;
    step(1);
  endtask

  task automatic test_buttons();
    bus.game_state = PROGRAM;
    press(7'd5, 1'b0, 1'b1);
    checks++;
    if (bus.board[5] !== 1'b1) begin
      errors++; $display("FAIL btn1_set: bit5=%b expected 1", bus.board[5]);
    end
    press(7'd5, 1'b1, 1'b1);
    checks++;
    if (bus.board[5] !== 1'b1) begin
      errors++; $display("FAIL both_btn_set_cell: bit5=%b expected 1", bus.board[5]);
    end
    press(7'd5, 1'b1, 1'b0);
    checks++;
    if (bus.board[5] !== 1'b0) begin
      errors++; $display("FAIL btn0_clear: bit5=%b expected 0", bus.board[5]);
    end
    press(7'd5, 1'b1, 1'b1);
    checks++;
    if (bus.board[5] !== 1'b0) begin
      errors++; $display("FAIL both_btn_clear_cell: bit5=%b expected 0", bus.board[5]);
    end
    press(7'd9, 1'b0, 1'b1);
    press(7'd9, 1'b0, 1'b0);
    checks++;
    if (bus.board !== (64'd1 << 9)) begin
      errors++; $display("FAIL no_btn_hold: board=%h expected %h", bus.board, 64'd1 << 9);
    end
    bus.game_state = IDLE;
    step(1);
    checks++;
    if (bus.board !== '0) begin
      errors++; $display("FAIL idle_clear: board=%h expected 0", bus.board);
    end
  endtask

  task automatic test_blinker();
    int found;
    int busy_cnt;
    bus.game_state = PROGRAM;
    press(7'd26, 1'b0, 1'b1);
    press(7'd27, 1'b0, 1'b1);
    press(7'd28, 1'b0, 1'b1);
    press(7'(200), 1'b0, 1'b1);
    step(1);
    checks++;
    if (bus.alive_count !== 7'd3 || bus.board !== BLINK_H) begin
      errors++;
      $display("FAIL blinker_program: board=%h alive=%0d, expected %h alive=3",
               bus.board, bus.alive_count, BLINK_H);
    end
    bus.game_state = RUN;   // cycle 0
    found    = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      step(1);
      if (k == 1) begin bus.cell_idx = 7'd0; bus.btn1 = 1'b1; end
      if (k == 2) bus.btn1 = 1'b0;
      if (k == 10) begin
        checks++;
        if (bus.board !== BLINK_H) begin
          errors++; $display("FAIL run_btn_ignored: board=%h expected %h", bus.board, BLINK_H);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.gen_done) begin found = k; break; end
    end
    checks++;
    if (found !== 1 + P + N) begin
      errors++; $display("FAIL first_gen_latency: cycle=%0d expected %0d", found, 1 + P + N);
    end
    checks++;
    if (busy_cnt !== N) begin
      errors++; $display("FAIL busy_length: busy cycles=%0d expected %0d", busy_cnt, N);
    end
    step(1);
    checks++;
    if (bus.board !== BLINK_V || bus.generation !== 16'd1 || bus.alive_count !== 7'd3 || bus.gen_done !== 1'b0) begin
      errors++;
      $display("FAIL blinker_gen1: board=%h gen=%0d alive=%0d done=%b, expected %h gen=1 alive=3 done=0",
               bus.board, bus.generation, bus.alive_count, bus.gen_done, BLINK_V);
    end
    found = 0;
    for (int k = 2; k <= 200; k++) begin
      step(1);
      if (bus.gen_done) begin found = k; break; end
    end
    checks++;
    if (found !== P + N + 1) begin
      errors++; $display("FAIL gen_spacing: spacing=%0d expected %0d", found, P + N + 1);
    end
    step(1);
    checks++;
    if (bus.board !== BLINK_H || bus.generation !== 16'd2) begin
      errors++;
      $display("FAIL blinker_gen2: board=%h gen=%0d, expected %h gen=2", bus.board, bus.generation, BLINK_H);
    end
  endtask

  task automatic test_pause_sweep();
    int  waited;
    int  pulses;
    logic prev_done;
    logic wide;
    logic changed;
    logic [N-1:0] snap;
    waited = 0;
    while (!bus.busy && waited < 200) begin step(1); waited++; end
    step(30);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL pause_sweep_busy: busy=%b expected 1", bus.busy);
    end
    bus.game_state = PAUSE;
    bus.cell_idx   = 7'd0;
    pulses    = 0;
    prev_done = 1'b0;
    wide      = 1'b0;
    for (int k = 0; k < 600; k++) begin
      step(1);
      if (k == 50) bus.btn1 = 1'b1;
      if (k == 51) bus.btn1 = 1'b0;
      if (bus.gen_done) pulses++;
      if (bus.gen_done && prev_done) wide = 1'b1;
      prev_done = bus.gen_done;
    end
    checks++;
    if (pulses !== 1 || wide) begin
      errors++; $display("FAIL pause_sweep_pulses: pulses=%0d wide=%b expected 1 wide=0", pulses, wide);
    end
    checks++;
    if (bus.generation !== 16'd3 || bus.board !== BLINK_V || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_sweep_commit: board=%h gen=%0d busy=%b, expected %h gen=3 busy=0",
               bus.board, bus.generation, bus.busy, BLINK_V);
    end
    snap    = bus.board;
    changed = 1'b0;
    for (int k = 0; k < 500; k++) begin
      step(1);
      if (bus.board !== snap || bus.generation !== 16'd3 || bus.gen_done || bus.busy) changed = 1'b1;
    end
    checks++;
    if (changed) begin
      errors++; $display("FAIL pause_hold: changed=%b expected 0", changed);
    end
  endtask

  task automatic test_pause_count();
    int offset;
    bus.game_state = RUN;     // cycle 0, engine in HOLD
    step(3);                  // cycle 3: counter shows 2
    bus.game_state = PAUSE;
    step(5);                  // cycles 3..7 paused, counter frozen at 2
    bus.game_state = RUN;
    offset = 1;               // counted from the last paused cycle
    while (offset < 200) begin
      step(1);
      offset++;
      if (bus.gen_done) break;
    end
    // Counter 2 -> 3 (one more count), N sweep cycles, then the commit cycle.
    checks++;
    if (offset !== 2 + N + 1) begin
      errors++; $display("FAIL pause_count_resume: cycles=%0d expected %0d", offset, 2 + N + 1);
    end
    step(1);
    checks++;
    if (bus.generation !== 16'd4 || bus.board !== BLINK_H) begin
      errors++;
      $display("FAIL pause_count_gen: board=%h gen=%0d, expected %h gen=4", bus.board, bus.generation, BLINK_H);
    end
  endtask

  task automatic test_idle_sweep();
    int   waited;
    logic seen;
    waited = 0;
    while (!bus.busy && waited < 200) begin step(1); waited++; end
    step(10);
    bus.game_state = IDLE;
    step(1);
    checks++;
    if (bus.board !== '0 || bus.generation !== 16'd0 || bus.busy !== 1'b0 ||
        bus.alive_count !== 7'd0 || bus.gen_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: board=%h gen=%0d busy=%b alive=%0d done=%b, expected all zero",
               bus.board, bus.generation, bus.busy, bus.alive_count, bus.gen_done);
    end
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step(1);
      if (bus.gen_done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL idle_no_done: gen_done seen=%b expected 0", seen);
    end
  endtask

  task automatic test_wrap();
    int gens;
    int cells[5] = '{1, 10, 16, 17, 18};
    gbus.game_state = PROGRAM;
    foreach (cells[i]) begin
      gbus.cell_idx = 7'(cells[i]);
      gbus.btn1     = 1'b1;
      step(1);
      gbus.btn1 = 1'b0;
    end
    step(1);
    checks++;
    if (gbus.board !== GLIDER_0 || gbus.alive_count !== 7'd5) begin
      errors++;
      $display("FAIL glider_program: board=%h alive=%0d, expected %h alive=5", gbus.board, gbus.alive_count, GLIDER_0);
    end
    gbus.game_state = RUN;
    gens = 0;
    for (int k = 0; k < 2500 && gens < 32; k++) begin
      step(1);
      if (gbus.gen_done) begin
        gens++;
        step(1);
        checks++;
        if (gbus.alive_count !== 7'd5) begin
          errors++; $display("FAIL glider_alive_gen%0d: alive=%0d expected 5", gens, gbus.alive_count);
        end
        if (gens == 4) begin
          checks++;
          if (gbus.board !== GLIDER_4) begin
            errors++; $display("FAIL glider_shift4: board=%h expected %h", gbus.board, GLIDER_4);
          end
        end
      end
    end
    checks++;
    if (gens !== 32 || gbus.board !== GLIDER_0 || gbus.generation !== 16'd32) begin
      errors++;
      $display("FAIL glider_wrap32: gens=%0d board=%h gen=%0d, expected 32 %h gen=32",
               gens, gbus.board, gbus.generation, GLIDER_0);
    end
    gbus.game_state = IDLE;
    step(1);
  endtask

  initial begin
    test_reset();
    test_buttons();
    test_blinker();
    test_pause_sweep();
    test_pause_count();
    test_idle_sweep();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
